// File: rtl/eth_mdio_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : eth_mdio_pkg
//  Purpose  : Shared constants and state type for the clause-22 MDIO master.
//             Holds the frame field codes, the preamble and frame lengths,
//             and the controller state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package eth_mdio_pkg;

   // Clause-22 frame field codes
   localparam logic [1:0] MDIO_ST         = 2'b01;
   localparam logic [1:0] MDIO_OP_WR      = 2'b01;
   localparam logic [1:0] MDIO_OP_RD      = 2'b10;
   localparam logic [1:0] MDIO_TA_WR      = 2'b10;

   // Frame geometry in MDC bit periods
   localparam int         MDIO_PRE_BITS   = 32;
   localparam int         MDIO_FRAME_BITS = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } mdio_state_e;

endpackage
`default_nettype wire

// File: rtl/eth_mdio_clkgen.sv
`default_nettype none
// ============================================================================
//  Module   : eth_mdio_clkgen
//  Purpose  : MDC generator. Divides clk_i by 2*CLK_DIV while run_i is high,
//             producing the registered MDC level plus single-cycle strobes
//             that mark the cycle in which MDC is about to rise or fall.
//             Cleared (counter 0, MDC low) whenever run_i is low.
//  Ports    : clk_i, rst_i   clock, asynchronous active-high reset
//             run_i          1 = frame in progress, 0 = hold cleared
//             mdc_o          management clock (registered)
//             fall_stb       MDC goes 1->0 at the next clk_i edge
//             rise_stb       MDC goes 0->1 at the next clk_i edge
//  Revision : 1.0  initial release
// ============================================================================
module eth_mdio_clkgen #(
   parameter int CLK_DIV = 50
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic run_i,
   output logic mdc_o,
   output logic fall_stb,
   output logic rise_stb
);

   localparam int                 c_cnt_w   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(CLK_DIV - 1);

   logic [c_cnt_w-1:0] r_cnt;
   logic               w_wrap;

   // End of a half-period: MDC toggles at the coming edge
   assign w_wrap   = run_i && (r_cnt == c_cnt_max);
   assign rise_stb = w_wrap && !mdc_o;
   assign fall_stb = w_wrap &&  mdc_o;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_cnt <= '0;
         mdc_o <= 1'b0;
      end else if (!run_i) begin
         r_cnt <= '0;
         mdc_o <= 1'b0;
      end else if (w_wrap) begin
         r_cnt <= '0;
         mdc_o <= ~mdc_o;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/eth_mdio_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : eth_mdio_ctrl
//  Purpose  : IEEE 802.3 clause-22 MDIO master. Accepts one PHY register
//             read or write per valid/ready handshake, serialises the frame
//             MSB first on MDC/MDIO and returns a one-cycle response strobe
//             with the read data.
//  Ports    : clk_i, rst_i          clock, asynchronous active-high reset
//             req_valid_i/ready_o   request handshake
//             req_write_i           1 = write, 0 = read
//             req_phy_i, req_reg_i  PHY and register address
//             req_wdata_i           write data
//             rsp_valid_o           one-cycle completion strobe
//             rsp_rdata_o           data of the last completed read
//             busy_o                frame in progress
//             mdc_o                 management clock
//             mdio_i                MDIO pad input (asynchronous)
//             mdio_o, mdio_oe_o     MDIO output value and output enable
//  Revision : 1.0  initial release
// ============================================================================
module eth_mdio_ctrl
   import eth_mdio_pkg::*;
#(
   parameter int CLK_DIV     = 50,
   parameter bit PREAMBLE_EN = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_write_i,
   input  logic [4:0]  req_phy_i,
   input  logic [4:0]  req_reg_i,
   input  logic [15:0] req_wdata_i,
   output logic        rsp_valid_o,
   output logic [15:0] rsp_rdata_o,
   output logic        busy_o,
   output logic        mdc_o,
   input  logic        mdio_i,
   output logic        mdio_o,
   output logic        mdio_oe_o
);

   localparam int         c_pre      = PREAMBLE_EN ? MDIO_PRE_BITS : 0;
   localparam int         c_nbits    = c_pre + MDIO_FRAME_BITS;
   // Bit indices within the frame (0 = first bit on the wire)
   localparam logic [5:0] c_last_bit = 6'(c_nbits - 1);
   localparam logic [5:0] c_ta_bit   = 6'(c_pre + 14);
   localparam logic [5:0] c_data_bit = 6'(c_pre + 16);

   mdio_state_e r_state;
   logic [63:0] r_shift;
   logic        r_read;
   logic [5:0]  r_bit;
   logic [15:0] r_rd;
   logic [1:0]  r_sync;

   logic        w_run;
   logic        w_fall;
   logic        w_rise;
   logic [31:0] w_frame;
   logic [63:0] w_load;

   // Frame body; for reads the TA/DATA slots are never driven (oe low)
   assign w_frame = {MDIO_ST,
                     req_write_i ? MDIO_OP_WR : MDIO_OP_RD,
                     req_phy_i,
                     req_reg_i,
                     req_write_i ? MDIO_TA_WR  : 2'b11,
                     req_write_i ? req_wdata_i : 16'hFFFF};

   // Frame is left-aligned so the first bit is always r_shift[63]
   if (PREAMBLE_EN) begin : g_pre
      assign w_load = {32'hFFFF_FFFF, w_frame};
   end else begin : g_nopre
      assign w_load = {w_frame, 32'h0000_0000};
   end

   assign w_run = (r_state == SHIFT);

   eth_mdio_clkgen #(
      .CLK_DIV (CLK_DIV)
   ) u_clkgen (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .run_i    (w_run),
      .mdc_o    (mdc_o),
      .fall_stb (w_fall),
      .rise_stb (w_rise)
   );

   // Two-flop synchroniser; idles high like the pulled-up pad
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_sync <= 2'b11;
      end else begin
         r_sync <= {r_sync[0], mdio_i};
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= IDLE;
         req_ready_o <= 1'b1;
         busy_o      <= 1'b0;
         rsp_valid_o <= 1'b0;
         rsp_rdata_o <= 16'h0000;
         mdio_o      <= 1'b1;
         mdio_oe_o   <= 1'b0;
         r_shift     <= 64'h0;
         r_read      <= 1'b0;
         r_bit       <= 6'd0;
         r_rd        <= 16'h0000;
      end else begin
         rsp_valid_o <= 1'b0;
         case (r_state)
            IDLE: begin
               if (req_valid_i) begin
                  r_state     <= SHIFT;
                  req_ready_o <= 1'b0;
                  busy_o      <= 1'b1;
                  // First bit goes straight to the pin; the rest wait in r_shift
                  mdio_o      <= w_load[63];
                  mdio_oe_o   <= 1'b1;
                  r_shift     <= {w_load[62:0], 1'b0};
                  r_read      <= !req_write_i;
                  r_bit       <= 6'd0;
               end
            end
            SHIFT: begin
               if (w_rise && r_read && (r_bit >= c_data_bit)) begin
                  r_rd <= {r_rd[14:0], r_sync[1]};
               end
               if (w_fall) begin
                  if (r_bit == c_last_bit) begin
                     r_state     <= DONE;
                     rsp_valid_o <= 1'b1;
                     mdio_o      <= 1'b1;
                     mdio_oe_o   <= 1'b0;
                     if (r_read) begin
                        rsp_rdata_o <= r_rd;
                     end
                  end else begin
                     r_bit   <= r_bit + 6'd1;
                     mdio_o  <= r_shift[63];
                     r_shift <= {r_shift[62:0], 1'b0};
                     // Release the line to the PHY from the first TA bit on
                     if (r_read && ((r_bit + 6'd1) == c_ta_bit)) begin
                        mdio_oe_o <= 1'b0;
                     end
                  end
               end
            end
            DONE: begin
               r_state     <= IDLE;
               req_ready_o <= 1'b1;
               busy_o      <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_eth_mdio_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_eth_mdio_ctrl
//  Purpose  : Self-checking bench for eth_mdio_ctrl. Two instances run in
//             parallel (CLK_DIV=4, with and without preamble). Each has a
//             PHY model that captures the frame on MDC rising edges and
//             answers reads, a scoreboard queue filled at acceptance, and a
//             monitor that checks every response against it.
//  Revision : 1.0  initial release
// ============================================================================
module tb_eth_mdio_ctrl;

   localparam int c_div = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        w;
      logic [4:0]  phy;
      logic [4:0]  rg;
      logic [15:0] wd;
      logic [15:0] rd;
      int          acc;
   } exp_t;

   // Simulated PHYs answer at addresses 1 and 5 (preamble instance only)
   function automatic bit phy_present(input bit en, input logic [4:0] p);
      return en && ((p == 5'd1) || (p == 5'd5));
   endfunction

   function automatic logic [15:0] phy_val(input logic [4:0] p, input logic [4:0] r);
      if ((p == 5'd1) && (r == 5'd2)) return 16'h0141;
      return {p, r, 6'h2B} ^ {r, 3'b101, p, 3'b011};
   endfunction

   // Expected wire bits, first bit in [63]
   function automatic logic [63:0] exp_frame(input logic w, input logic [4:0] p,
                                             input logic [4:0] r, input logic [15:0] d,
                                             input bit pre);
      logic [31:0] body;
      body = {2'b01, (w ? 2'b01 : 2'b10), p, r, 2'b10, d};
      return pre ? {32'hFFFF_FFFF, body} : {body, 32'h0};
   endfunction

   task automatic chk(input int inst, input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL inst%0d %s: got %0h, want %0h (cycle %0d)", inst, nm, act, exp, cyc);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam bit c_pre_en = (g == 0);
      localparam int c_p      = c_pre_en ? 32 : 0;
      localparam int c_n      = c_p + 32;

      logic        rst       = 1'b1;
      logic        req_valid = 1'b0;
      logic        req_write = 1'b0;
      logic [4:0]  req_phy   = 5'd0;
      logic [4:0]  req_reg   = 5'd0;
      logic [15:0] req_wdata = 16'h0;
      logic        mdio_in   = 1'b1;
      logic        req_ready, rsp_valid, busy, mdc, mdio_out, mdio_oe;
      logic [15:0] rsp_rdata;

      exp_t        exp_q[$];
      logic [63:0] cap_d, cap_oe;
      int          pidx    = 0;
      int          cap_len = 0;
      logic [15:0] last_rd = 16'h0;
      logic        prev_rsp = 1'b0;
      bit          done_flag = 1'b0;

      logic        p_rd;
      logic [4:0]  p_phy, p_reg;
      logic [15:0] p_val;

      eth_mdio_ctrl #(
         .CLK_DIV     (c_div),
         .PREAMBLE_EN (c_pre_en)
      ) u_dut (
         .clk_i       (clk),
         .rst_i       (rst),
         .req_valid_i (req_valid),
         .req_ready_o (req_ready),
         .req_write_i (req_write),
         .req_phy_i   (req_phy),
         .req_reg_i   (req_reg),
         .req_wdata_i (req_wdata),
         .rsp_valid_o (rsp_valid),
         .rsp_rdata_o (rsp_rdata),
         .busy_o      (busy),
         .mdc_o       (mdc),
         .mdio_i      (mdio_in),
         .mdio_o      (mdio_out),
         .mdio_oe_o   (mdio_oe)
      );

      // PHY model: captures each bit at MDC rise, drives read data for the
      // following bit right after that rise
      always @(posedge mdc or posedge rst or posedge rsp_valid) begin
         if (rst) begin
            pidx    = 0;
            mdio_in = 1'b1;
         end else if (rsp_valid) begin
            cap_len = pidx;
            pidx    = 0;
            mdio_in = 1'b1;
         end else begin
            if (pidx < 64) begin
               cap_d[63-pidx]  = mdio_out;
               cap_oe[63-pidx] = mdio_oe;
            end
            pidx++;
            mdio_in = 1'b1;
            if (pidx >= c_p + 15) begin
               p_rd  = (cap_d[61-c_p] == 1'b1) && (cap_d[60-c_p] == 1'b0);
               p_phy = cap_d[59-c_p -: 5];
               p_reg = cap_d[54-c_p -: 5];
               p_val = phy_val(p_phy, p_reg);
               if (p_rd && phy_present(c_pre_en, p_phy)) begin
                  if (pidx == c_p + 15) mdio_in = 1'b0;
                  else if (pidx < c_p + 32) mdio_in = p_val[15-(pidx-c_p-16)];
               end
            end
         end
      end

      // Monitor / scoreboard
      always @(negedge clk) begin
         exp_t        e;
         logic [63:0] f;
         int          bad;
         bit          oe_exp;
         if (rst) begin
            exp_q.delete();
            last_rd  = 16'h0;
            prev_rsp = 1'b0;
         end else begin
            chk(g, "busy_vs_ready", busy, !req_ready);
            if (prev_rsp) begin
               chk(g, "ready_after_done", req_ready, 1'b1);
               chk(g, "rsp_one_cycle", rsp_valid, 1'b0);
            end
            if (req_ready) begin
               chk(g, "idle_mdc", mdc, 1'b0);
               chk(g, "idle_oe", mdio_oe, 1'b0);
               chk(g, "idle_mdio", mdio_out, 1'b1);
               chk(g, "idle_rsp", rsp_valid, 1'b0);
            end
            if (rsp_valid) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL inst%0d unexpected_rsp: got rsp_valid=1, want no response (cycle %0d)", g, cyc);
               end else begin
                  e = exp_q.pop_front();
                  chk(g, "latency", cyc - e.acc, 2 * c_div * c_n + 1);
                  chk(g, "frame_len", cap_len, c_n);
                  f   = exp_frame(e.w, e.phy, e.rg, e.wd, c_pre_en);
                  bad = 0;
                  for (int k = 0; k < c_n; k++) begin
                     oe_exp = e.w || (k < c_p + 14);
                     if ((cap_oe[63-k] !== oe_exp) || (oe_exp && (cap_d[63-k] !== f[63-k])))
                        bad++;
                  end
                  chk(g, "frame_bad_bits", bad, 0);
                  chk(g, "rdata", rsp_rdata, e.w ? last_rd : e.rd);
                  if (!e.w) last_rd = e.rd;
                  chk(g, "done_mdc", mdc, 1'b0);
                  chk(g, "done_oe", mdio_oe, 1'b0);
                  chk(g, "done_mdio", mdio_out, 1'b1);
                  chk(g, "done_ready", req_ready, 1'b0);
               end
            end
            prev_rsp = rsp_valid;
         end
      end

      // Called right after a negedge; returns right after a negedge
      task automatic issue(input logic w, input logic [4:0] p, input logic [4:0] r,
                           input logic [15:0] d, input bit keep);
         exp_t e;
         int   n;
         req_valid = 1'b1;
         req_write = w;
         req_phy   = p;
         req_reg   = r;
         req_wdata = d;
         n = 0;
         while (!req_ready && n < 3000) begin
            @(negedge clk);
            n++;
         end
         if (!req_ready) begin
            checks++;
            failures++;
            $display("FAIL inst%0d accept_timeout: got req_ready=0, want 1 within 3000 cycles", g);
         end else begin
            e.w   = w;
            e.phy = p;
            e.rg  = r;
            e.wd  = d;
            e.rd  = phy_present(c_pre_en, p) ? phy_val(p, r) : 16'hFFFF;
            e.acc = cyc;
            exp_q.push_back(e);
         end
         @(negedge clk);
         if (!keep) req_valid = 1'b0;
      endtask

      task automatic wait_idle();
         int n;
         n = 0;
         while ((exp_q.size() != 0 || !req_ready) && n < 3000) begin
            @(negedge clk);
            n++;
         end
         if (exp_q.size() != 0 || !req_ready) begin
            checks++;
            failures++;
            $display("FAIL inst%0d idle_timeout: got %0d pending, want 0", g, exp_q.size());
         end
      endtask

      initial begin
         logic [4:0] rp;
         int         n;
         repeat (3) @(posedge clk);
         @(negedge clk);
         chk(g, "rst_ready", req_ready, 1'b1);
         chk(g, "rst_rsp_valid", rsp_valid, 1'b0);
         chk(g, "rst_rdata", rsp_rdata, 16'h0);
         chk(g, "rst_busy", busy, 1'b0);
         chk(g, "rst_mdc", mdc, 1'b0);
         chk(g, "rst_mdio", mdio_out, 1'b1);
         chk(g, "rst_oe", mdio_oe, 1'b0);
         rst = 1'b0;
         @(negedge clk);

         // Directed write then read
         issue(1'b1, 5'h01, 5'h00, 16'h1140, 1'b0);
         issue(1'b0, 5'h01, 5'h02, 16'h0000, 1'b0);
         wait_idle();

         // Back-to-back random requests with valid held high
         for (int i = 0; i < 6; i++) begin
            case ($urandom % 3)
               0:       rp = 5'd1;
               1:       rp = 5'd5;
               default: rp = 5'($urandom % 32);
            endcase
            issue(1'($urandom % 2), rp, 5'($urandom % 32), 16'($urandom), (i < 5));
         end
         wait_idle();

         // Reset in the middle of DATA bit 7 of a read
         issue(1'b0, 5'h05, 5'h07, 16'h0000, 1'b0);
         n = 0;
         while (pidx <= c_p + 24 && n < 3000) begin
            @(negedge clk);
            n++;
         end
         if (pidx <= c_p + 24) begin
            checks++;
            failures++;
            $display("FAIL inst%0d data_bit7_timeout: got bit %0d, want %0d", g, pidx, c_p + 25);
         end
         rst = 1'b1;
         #1;
         chk(g, "midrst_oe", mdio_oe, 1'b0);
         chk(g, "midrst_mdc", mdc, 1'b0);
         chk(g, "midrst_mdio", mdio_out, 1'b1);
         chk(g, "midrst_ready", req_ready, 1'b1);
         chk(g, "midrst_rsp", rsp_valid, 1'b0);
         repeat (2) @(negedge clk);
         rst = 1'b0;
         repeat (600) @(negedge clk);

         // Normal traffic after the aborted frame
         issue(1'b1, 5'h03, 5'h04, 16'hBEEF, 1'b0);
         issue(1'b0, 5'h01, 5'h02, 16'h0000, 1'b0);
         wait_idle();
         done_flag = 1'b1;
      end
   end

   initial begin
      while (!(g_inst[0].done_flag && g_inst[1].done_flag) && cyc < 60000) @(negedge clk);
      if (!(g_inst[0].done_flag && g_inst[1].done_flag)) begin
         checks++;
         failures++;
         $display("FAIL global_timeout: got unfinished bench at cycle %0d, want done", cyc);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
